aq_ifu_ibuf_align: RTL and testbench

//  Downstream stage of the instruction buffer entries. Views the two oldest entries (head0, head1),

---
 rtl/aq_ifu_ibuf_align.sv | 125 ++++++++++++
 tb/tb_aq_ifu_ibuf_align.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/aq_ifu_ibuf_align.sv
// Aligns the two oldest ibuf halfwords into one RV16/RV32 instruction and registers it toward IDU.
// Latency: head valid -> ifu_idu_inst_vld is 1 cycle, with combinational retire pulses in the load cycle.
// Backpressure: idu_ifu_stall freezes a valid output and blocks retire. Optional IBUF_ALIGN_PERF_CNT_EN.
module aq_ifu_ibuf_align #(
   parameter int HINFO_WIDTH = 22,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   forever_cpuclk,
   input  logic                   cpurst,
   input  logic                   ibuf_flush_en,
   input  logic                   ibuf_head0_vld,
   input  logic [15:0]            ibuf_head0_inst,
   input  logic [1:0]             ibuf_head0_pred_taken,
   input  logic                   ibuf_head0_acc_err,
   input  logic                   ibuf_head0_pgflt,
   input  logic [HINFO_WIDTH-1:0] ibuf_head0_halt_info,
   input  logic                   ibuf_head1_vld,
   input  logic [15:0]            ibuf_head1_inst,
   input  logic [1:0]             ibuf_head1_pred_taken,
   input  logic                   ibuf_head1_acc_err,
   input  logic                   ibuf_head1_pgflt,
   input  logic [HINFO_WIDTH-1:0] ibuf_head1_halt_info,
   input  logic                   idu_ifu_stall,
   output logic                   align_retire0_en,
   output logic                   align_retire1_en,
   output logic                   ifu_idu_inst_vld,
   output logic [31:0]            ifu_idu_inst,
   output logic                   ifu_idu_inst_32,
   output logic [1:0]             ifu_idu_pred_taken,
   output logic [HINFO_WIDTH-1:0] ifu_idu_halt_info,
   output logic                   ifu_idu_acc_err,
   output logic                   ifu_idu_pgflt,
   output logic                   ifu_idu_expt_hi,
   output logic [CNT_WIDTH-1:0]   ifu_perf_wait_hi_cnt
);

   typedef struct packed {
      logic [31:0]            inst;
      logic                   inst_32;
      logic [1:0]             pred_taken;
      logic [HINFO_WIDTH-1:0] halt_info;
      logic                   acc_err;
      logic                   pgflt;
      logic                   expt_hi;
   } idu_dat_t;

   logic     is16, f0, f1, cand, load;
   logic     out_vld;
   idu_dat_t out_dat, nxt_dat;
   logic     unused_h1_hinfo;

   assign unused_h1_hinfo = ^ibuf_head1_halt_info;

   assign is16 = ibuf_head0_inst[1:0] != 2'b11;
   assign f0   = ibuf_head0_acc_err | ibuf_head0_pgflt;
   assign f1   = ibuf_head1_acc_err | ibuf_head1_pgflt;
   assign cand = ibuf_head0_vld & (is16 | f0 | ibuf_head1_vld);
   assign load = cand & (!out_vld | !idu_ifu_stall) & !ibuf_flush_en & !cpurst;

   assign align_retire0_en = load;
   assign align_retire1_en = load & !is16 & !f0;

   // A faulting head0 is issued alone as a 16-bit slot so the trap reports pc, not pc+2.
   always_comb begin
      nxt_dat            = '0;
      nxt_dat.halt_info  = ibuf_head0_halt_info;
      if (is16 | f0) begin
         nxt_dat.inst       = {16'b0, ibuf_head0_inst};
         nxt_dat.pred_taken = ibuf_head0_pred_taken;
         nxt_dat.acc_err    = ibuf_head0_acc_err;
         nxt_dat.pgflt      = ibuf_head0_pgflt;
      end else begin
         nxt_dat.inst       = {ibuf_head1_inst, ibuf_head0_inst};
         nxt_dat.inst_32    = 1'b1;
         nxt_dat.pred_taken = ibuf_head1_pred_taken;
         nxt_dat.acc_err    = ibuf_head1_acc_err;
         nxt_dat.pgflt      = ibuf_head1_pgflt;
         nxt_dat.expt_hi    = f1;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         out_vld <= 1'b0;
         out_dat <= '0;
      end else begin
         if (ibuf_flush_en)
            out_vld <= 1'b0;
         else if (load)
            out_vld <= 1'b1;
         else if (!idu_ifu_stall)
            out_vld <= 1'b0;
         if (load)
            out_dat <= nxt_dat;
      end
   end

   assign ifu_idu_inst_vld   = out_vld;
   assign ifu_idu_inst       = out_dat.inst;
   assign ifu_idu_inst_32    = out_dat.inst_32;
   assign ifu_idu_pred_taken = out_dat.pred_taken;
   assign ifu_idu_halt_info  = out_dat.halt_info;
   assign ifu_idu_acc_err    = out_dat.acc_err;
   assign ifu_idu_pgflt      = out_dat.pgflt;
   assign ifu_idu_expt_hi    = out_dat.expt_hi;

`ifdef IBUF_ALIGN_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] wait_hi_cnt;
   logic                 wait_hi;

   assign wait_hi = ibuf_head0_vld & !is16 & !f0 & !ibuf_head1_vld & !ibuf_flush_en;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst)
         wait_hi_cnt <= '0;
      else if (wait_hi && (wait_hi_cnt != {CNT_WIDTH{1'b1}}))
         wait_hi_cnt <= wait_hi_cnt + CNT_WIDTH'(1);
   end

   assign ifu_perf_wait_hi_cnt = wait_hi_cnt;
`else
   assign ifu_perf_wait_hi_cnt = '0;
`endif

endmodule

// File: tb/tb_aq_ifu_ibuf_align.sv
// Directed bench for aq_ifu_ibuf_align with hand-computed expectations.
module tb_aq_ifu_ibuf_align;
   localparam int HW = 22;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          h0_vld, h1_vld;
   logic [15:0]   h0_inst, h1_inst;
   logic [1:0]    h0_pred, h1_pred;
   logic          h0_acc, h0_pf, h1_acc, h1_pf;
   logic [HW-1:0] h0_hi, h1_hi;
   logic          stall;
   logic          ret0, ret1, o_vld, o_32, o_acc, o_pf, o_ehi;
   logic [31:0]   o_inst;
   logic [1:0]    o_pred;
   logic [HW-1:0] o_hinfo;
   logic [CW-1:0] o_cnt;

   int nvec = 0;
   int nerr = 0;

`ifdef IBUF_ALIGN_PERF_CNT_EN
   localparam logic [CW-1:0] CNT_EXP = 32'd3;
`else
   localparam logic [CW-1:0] CNT_EXP = 32'd0;
`endif

   always #5 clk = ~clk;

   aq_ifu_ibuf_align #(.HINFO_WIDTH(HW), .CNT_WIDTH(CW)) dut (
      .forever_cpuclk        (clk),
      .cpurst                (rst),
      .ibuf_flush_en         (flush),
      .ibuf_head0_vld        (h0_vld),
      .ibuf_head0_inst       (h0_inst),
      .ibuf_head0_pred_taken (h0_pred),
      .ibuf_head0_acc_err    (h0_acc),
      .ibuf_head0_pgflt      (h0_pf),
      .ibuf_head0_halt_info  (h0_hi),
      .ibuf_head1_vld        (h1_vld),
      .ibuf_head1_inst       (h1_inst),
      .ibuf_head1_pred_taken (h1_pred),
      .ibuf_head1_acc_err    (h1_acc),
      .ibuf_head1_pgflt      (h1_pf),
      .ibuf_head1_halt_info  (h1_hi),
      .idu_ifu_stall         (stall),
      .align_retire0_en      (ret0),
      .align_retire1_en      (ret1),
      .ifu_idu_inst_vld      (o_vld),
      .ifu_idu_inst          (o_inst),
      .ifu_idu_inst_32       (o_32),
      .ifu_idu_pred_taken    (o_pred),
      .ifu_idu_halt_info     (o_hinfo),
      .ifu_idu_acc_err       (o_acc),
      .ifu_idu_pgflt         (o_pf),
      .ifu_idu_expt_hi       (o_ehi),
      .ifu_perf_wait_hi_cnt  (o_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic heads(input logic v0, input logic [15:0] i0, input logic v1, input logic [15:0] i1);
      h0_vld = v0; h0_inst = i0; h1_vld = v1; h1_inst = i1;
      h0_acc = 1'b0; h0_pf = 1'b0; h1_acc = 1'b0; h1_pf = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 1'b0;
      heads(1'b1, 16'h4501, 1'b0, 16'h0);
      h0_pred = 2'b00; h1_pred = 2'b00; h0_hi = '0; h1_hi = '0;
      step(); step();
      chk("rst_retire0", 64'(ret0), 64'd0);
      chk("rst_vld", 64'(o_vld), 64'd0);
      chk("rst_inst", 64'(o_inst), 64'd0);
      chk("rst_cnt", 64'(o_cnt), 64'd0);

      // 16-bit c.li
      rst = 1'b0;
      h0_pred = 2'b01; h0_hi = 22'h2AAAAA; h1_hi = 22'h155555;
      #2;
      chk("c16_ret0", 64'(ret0), 64'd1);
      chk("c16_ret1", 64'(ret1), 64'd0);
      step();
      chk("c16_vld", 64'(o_vld), 64'd1);
      chk("c16_inst", 64'(o_inst), 64'h0000_4501);
      chk("c16_32", 64'(o_32), 64'd0);
      chk("c16_pred", 64'(o_pred), 64'd1);
      chk("c16_hinfo", 64'(o_hinfo), 64'h2AAAAA);

      // 32-bit addi, both halves present
      heads(1'b1, 16'h0513, 1'b1, 16'h0010);
      h0_pred = 2'b01; h1_pred = 2'b10;
      #2;
      chk("i32_ret0", 64'(ret0), 64'd1);
      chk("i32_ret1", 64'(ret1), 64'd1);
      step();
      chk("i32_inst", 64'(o_inst), 64'h0010_0513);
      chk("i32_32", 64'(o_32), 64'd1);
      chk("i32_pred", 64'(o_pred), 64'd2);
      chk("i32_hinfo", 64'(o_hinfo), 64'h2AAAAA);
      chk("i32_ehi", 64'(o_ehi), 64'd0);

      // Upper half missing for 3 cycles
      heads(1'b1, 16'h0513, 1'b0, 16'h0010);
      for (int i = 0; i < 3; i++) begin
         #2;
         chk($sformatf("wait_ret0_%0d", i), 64'(ret0), 64'd0);
         step();
         chk($sformatf("wait_vld_%0d", i), 64'(o_vld), 64'd0);
      end
      h1_vld = 1'b1;
      #2;
      chk("wait_done_ret1", 64'(ret1), 64'd1);
      step();
      chk("wait_done_vld", 64'(o_vld), 64'd1);
      chk("wait_cnt", 64'(o_cnt), 64'(CNT_EXP));

      // Faulting 32-bit head0: issued alone
      heads(1'b1, 16'h0513, 1'b1, 16'h0010);
      h0_pf = 1'b1;
      #2;
      chk("pf0_ret0", 64'(ret0), 64'd1);
      chk("pf0_ret1", 64'(ret1), 64'd0);
      step();
      chk("pf0_pgflt", 64'(o_pf), 64'd1);
      chk("pf0_inst", 64'(o_inst), 64'h0000_0513);
      chk("pf0_32", 64'(o_32), 64'd0);
      chk("pf0_ehi", 64'(o_ehi), 64'd0);

      // Upper half access error
      heads(1'b1, 16'h0513, 1'b1, 16'h0010);
      h1_acc = 1'b1;
      #2;
      chk("ae1_ret1", 64'(ret1), 64'd1);
      step();
      chk("ae1_acc", 64'(o_acc), 64'd1);
      chk("ae1_pgflt", 64'(o_pf), 64'd0);
      chk("ae1_ehi", 64'(o_ehi), 64'd1);
      chk("ae1_32", 64'(o_32), 64'd1);

      // Stall holds output, new 16-bit head waiting
      heads(1'b1, 16'h4501, 1'b0, 16'h0);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #2;
         chk($sformatf("stl_ret0_%0d", i), 64'(ret0), 64'd0);
         step();
         chk($sformatf("stl_vld_%0d", i), 64'(o_vld), 64'd1);
         chk($sformatf("stl_inst_%0d", i), 64'(o_inst), 64'h0010_0513);
         chk($sformatf("stl_acc_%0d", i), 64'(o_acc), 64'd1);
      end
      stall = 1'b0;
      #2;
      chk("stl_drop_ret0", 64'(ret0), 64'd1);
      step();
      chk("stl_drop_inst", 64'(o_inst), 64'h0000_4501);
      chk("stl_drop_32", 64'(o_32), 64'd0);

      // Flush with a ready candidate
      flush = 1'b1;
      #2;
      chk("fl_ret0", 64'(ret0), 64'd0);
      step();
      chk("fl_vld", 64'(o_vld), 64'd0);
      flush = 1'b0;

      // Reset asserted while an instruction is held
      heads(1'b1, 16'h0513, 1'b1, 16'h0010);
      step();
      chk("rh_vld", 64'(o_vld), 64'd1);
      stall = 1'b1;
      rst = 1'b1;
      #2;
      chk("rh_ret0", 64'(ret0), 64'd0);
      step();
      chk("rh_vld0", 64'(o_vld), 64'd0);
      chk("rh_inst0", 64'(o_inst), 64'd0);
      chk("rh_32", 64'(o_32), 64'd0);
      chk("rh_cnt", 64'(o_cnt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
